nib_bus_sched: RTL and testbench

- Scheduler for the shared 4-bit operand bus of the nibble ALU core.
- Arbitrates between NREQ requesters (core ALU sequencer, host debug port) using round-robin priority.
- Serves each granted request from an internal 16x4 register file or from an external memory/IO nibble fetch with a ready handshake.
- One transaction in flight at a time; each request gets a single-cycle response pulse.

---
 rtl/nib_pkg.sv | 27 ++
 rtl/nib_regfile.sv | 54 +++++
 rtl/nib_bus_sched.sv | 181 ++++++++++++++++++
 tb/tb_nib_bus_sched.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/nib_pkg.sv
// Shared definitions for the nibble operand bus scheduler.
//   op_e    : request opcode carried on req_op
//   state_e : scheduler FSM states
//   NIB_W   : data width of the operand bus (one nibble)
//   REG_N   : number of registers in the internal register file
//   ADDR_W  : register / memory address width
package nib_pkg;

  localparam int NIB_W  = 4;
  localparam int REG_N  = 16;
  localparam int ADDR_W = 4;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_FETCH = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

endpackage

// File: rtl/nib_regfile.sv
// 16 x 4 register file for the nibble ALU core.
//   clk, rst_n : clock and asynchronous active-low clear (all entries -> 0)
//   we         : write enable
//   waddr      : write index
//   wdata      : write nibble
//   raddr      : read index
//   rdata      : combinational read data
// Entry 0 is hard-wired to zero: writes to it are dropped and reads return 0.
module nib_regfile
  import nib_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [NIB_W-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [NIB_W-1:0]  rdata
);

  logic [NIB_W-1:0] word [REG_N];

  genvar gi;
  generate
    for (gi = 0; gi < REG_N; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign word[gi] = '0;
      end else begin : g_entry
        logic [NIB_W-1:0] ent_q;
        logic [NIB_W-1:0] ent_d;

        always_comb begin
          ent_d = ent_q;
          if (we && (waddr == ADDR_W'(gi))) begin
            ent_d = wdata;
          end
        end

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            ent_q <= '0;
          end else begin
            ent_q <= ent_d;
          end
        end

        assign word[gi] = ent_q;
      end
    end
  endgenerate

  assign rdata = word[raddr];

endmodule

// File: rtl/nib_bus_sched.sv
// Scheduler for the shared 4-bit operand bus of the nibble ALU core.
// Round-robin arbitration between NREQ requesters; each granted request is
// served from the internal register file (READ/WRITE) or from an external
// memory/IO fetch with a ready handshake (FETCH), one transaction at a time.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/op/addr/wdata: per-requester request fields (packed per lane)
//   grant                 : one-hot, high for the whole served transaction
//   rsp_valid             : one-cycle response pulse to the served requester
//   rsp_data, rsp_err     : response nibble and error qualifier
//   ext_req/addr/data/ready: external nibble fetch handshake
//   busy                  : FSM not idle
module nib_bus_sched
  import nib_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [2*NREQ-1:0]     req_op,
  input  logic [4*NREQ-1:0]     req_addr,
  input  logic [4*NREQ-1:0]     req_wdata,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [NIB_W-1:0]      rsp_data,
  output logic                  rsp_err,
  output logic                  ext_req,
  output logic [ADDR_W-1:0]     ext_addr,
  input  logic [NIB_W-1:0]      ext_data,
  input  logic                  ext_ready,
  output logic                  busy
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  win_q, win_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NIB_W-1:0]  wdata_q, wdata_d;
  logic [NIB_W-1:0]  rsp_data_q, rsp_data_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              rf_we;
  logic [NIB_W-1:0]  rf_rdata;

  logic              found;
  logic [PTR_W-1:0]  pick;
  logic [NREQ-1:0]   win_onehot;

  nib_regfile u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (rf_we),
    .waddr (addr_q),
    .wdata (wdata_q),
    .raddr (addr_q),
    .rdata (rf_rdata)
  );

  // Rotating priority: search starts one past the last winner, so the
  // requester served most recently has the lowest priority next time.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!found && req_valid[(int'(ptr_q) + i) % NREQ]) begin
        found = 1'b1;
        pick  = PTR_W'((int'(ptr_q) + i) % NREQ);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    rf_we      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          // Latch the request so later changes on req_* are ignored.
          win_d   = pick;
          ptr_d   = pick;
          op_d    = op_e'(req_op[2*int'(pick) +: 2]);
          addr_d  = req_addr[4*int'(pick) +: 4];
          wdata_d = req_wdata[4*int'(pick) +: 4];
          err_d   = 1'b0;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        unique case (op_q)
          OP_READ: begin
            rsp_data_d = rf_rdata;
            state_d    = ST_RESP;
          end
          OP_WRITE: begin
            // Response echoes wdata even for register 0, where the write is dropped.
            rf_we      = 1'b1;
            rsp_data_d = wdata_q;
            state_d    = ST_RESP;
          end
          OP_FETCH: begin
            cnt_d   = '0;
            state_d = ST_WAIT;
          end
          default: begin
            err_d      = 1'b1;
            rsp_data_d = '0;
            state_d    = ST_RESP;
          end
        endcase
      end
      ST_WAIT: begin
        if (ext_ready) begin
          rsp_data_d = ext_data;
          state_d    = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d      = 1'b1;
          rsp_data_d = '0;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= PTR_W'(NREQ - 1);
      win_q      <= '0;
      op_q       <= OP_READ;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rsp_data_q <= rsp_data_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign win_onehot = NREQ'(1) << win_q;
  assign busy       = (state_q != ST_IDLE);
  assign grant      = busy ? win_onehot : '0;
  assign rsp_valid  = (state_q == ST_RESP) ? win_onehot : '0;
  assign rsp_err    = (state_q == ST_RESP) && err_q;
  assign rsp_data   = rsp_data_q;
  assign ext_req    = (state_q == ST_WAIT);
  assign ext_addr   = ext_req ? addr_q : '0;

endmodule

// File: tb/tb_nib_bus_sched.sv
// Directed self-checking bench for nib_bus_sched (NREQ=2, TIMEOUT=15).
module tb_nib_bus_sched;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [2*NREQ-1:0] req_op = '0;
  logic [4*NREQ-1:0] req_addr = '0;
  logic [4*NREQ-1:0] req_wdata = '0;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   rsp_valid;
  logic [3:0]        rsp_data;
  logic              rsp_err;
  logic              ext_req;
  logic [3:0]        ext_addr;
  logic [3:0]        ext_data = '0;
  logic              ext_ready = 1'b0;
  logic              busy;

  int checks = 0;
  int failures = 0;

  nib_bus_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .grant     (grant),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .ext_req   (ext_req),
    .ext_addr  (ext_addr),
    .ext_data  (ext_data),
    .ext_ready (ext_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [1:0] op, input logic [3:0] addr,
                         input logic [3:0] wdata);
    req_op[2*idx +: 2]    = op;
    req_addr[4*idx +: 4]  = addr;
    req_wdata[4*idx +: 4] = wdata;
    req_valid[idx]        = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_data"}, 32'(rsp_data), 0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 0);
    chk({tag, "_ext_req"}, 32'(ext_req), 0);
    chk({tag, "_ext_addr"}, 32'(ext_addr), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  // One register-file or reserved-op transaction: response exactly two edges
  // after the request is presented, then back to idle with data held.
  task automatic txn(input string tag, input int idx, input logic [1:0] op,
                     input logic [3:0] addr, input logic [3:0] wdata,
                     input logic [3:0] exp_data, input logic exp_err);
    logic [NREQ-1:0] oh;
    oh = NREQ'(1) << idx;
    set_req(idx, op, addr, wdata);
    step();
    chk({tag, "_exec_grant"}, 32'(grant), 32'(oh));
    chk({tag, "_exec_rsp_valid"}, 32'(rsp_valid), 0);
    step();
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(oh));
    chk({tag, "_rsp_data"}, 32'(rsp_data), 32'(exp_data));
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'(exp_err));
    req_valid[idx] = 1'b0;
    step();
    chk({tag, "_idle_grant"}, 32'(grant), 0);
    chk({tag, "_idle_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_idle_rsp_err"}, 32'(rsp_err), 0);
    chk({tag, "_hold_data"}, 32'(rsp_data), 32'(exp_data));
    $display("txn %s req=%0d op=%0d addr=%0h data=%0h err=%0b", tag, idx, op, addr,
             rsp_data, exp_err);
  endtask

  initial begin
    // Asynchronous reset, checked before any clock edge.
    #1 rst_n = 1'b0;
    #1 chk_all_zero("reset");
    step();
    @(negedge clk) rst_n = 1'b1;
    step();
    chk_all_zero("post_reset_idle");

    // WRITE then READ back through requester 0.
    txn("wr5", 0, 2'd1, 4'h5, 4'hA, 4'hA, 1'b0);
    txn("rd5", 0, 2'd0, 4'h5, 4'h0, 4'hA, 1'b0);

    // Fresh reset so the round-robin pointer restarts (requester 0 first).
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    step();
    set_req(0, 2'd0, 4'h5, 4'h0);
    set_req(1, 2'd0, 4'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_grant", 32'(grant), (k % 2 == 0) ? 32'd1 : 32'd2);
      step();
      chk("rr_rsp_valid", 32'(rsp_valid), (k % 2 == 0) ? 32'd1 : 32'd2);
      chk("rr_rsp_data", 32'(rsp_data), 0);
      if (k == 3) req_valid = '0;
      step();
      chk("rr_idle_grant", 32'(grant), 0);
      $display("txn rr%0d grant=%0b rsp_valid_seen", k, grant);
    end

    // FETCH via requester 1 with ext_ready in the 4th WAIT cycle.
    set_req(1, 2'd2, 4'h3, 4'h0);
    step();
    chk("fetch_exec_grant", 32'(grant), 2);
    chk("fetch_exec_ext_req", 32'(ext_req), 0);
    step();
    chk("fetch_wait_ext_req", 32'(ext_req), 1);
    chk("fetch_wait_ext_addr", 32'(ext_addr), 3);
    step();
    step();
    step();
    chk("fetch_wait4_ext_req", 32'(ext_req), 1);
    ext_ready = 1'b1;
    ext_data  = 4'h7;
    step();
    ext_ready = 1'b0;
    chk("fetch_rsp_valid", 32'(rsp_valid), 2);
    chk("fetch_rsp_data", 32'(rsp_data), 7);
    chk("fetch_rsp_err", 32'(rsp_err), 0);
    chk("fetch_rsp_ext_req", 32'(ext_req), 0);
    req_valid = '0;
    step();
    $display("txn fetch req=1 addr=3 data=%0h", rsp_data);

    // FETCH timeout via requester 0: ext_ready never arrives.
    set_req(0, 2'd2, 4'h9, 4'h0);
    step();
    chk("to_exec_grant", 32'(grant), 1);
    for (int w = 1; w <= TIMEOUT; w++) begin
      step();
      chk("to_wait_ext_req", 32'(ext_req), 1);
      chk("to_wait_rsp_valid", 32'(rsp_valid), 0);
    end
    step();
    chk("to_rsp_valid", 32'(rsp_valid), 1);
    chk("to_rsp_err", 32'(rsp_err), 1);
    chk("to_rsp_data", 32'(rsp_data), 0);
    chk("to_rsp_ext_req", 32'(ext_req), 0);
    req_valid = '0;
    step();
    chk("to_idle_rsp_err", 32'(rsp_err), 0);
    $display("txn timeout req=0 addr=9 err=1");

    // Register 0 behaviour and reserved op.
    txn("wr0", 1, 2'd1, 4'h0, 4'hF, 4'hF, 1'b0);
    txn("rd0", 1, 2'd0, 4'h0, 4'h0, 4'h0, 1'b0);
    txn("wr6", 0, 2'd1, 4'h6, 4'hC, 4'hC, 1'b0);
    txn("rsvd", 1, 2'd3, 4'h6, 4'h5, 4'h0, 1'b1);
    txn("rd6", 0, 2'd0, 4'h6, 4'h0, 4'hC, 1'b0);

    // Reset asserted during WAIT aborts the fetch and clears the register file.
    set_req(1, 2'd2, 4'h4, 4'h0);
    step();
    step();
    chk("rst_wait_ext_req", 32'(ext_req), 1);
    #3 rst_n = 1'b0;
    #1 chk_all_zero("mid_reset");
    req_valid = '0;
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("post_abort_rsp_valid", 32'(rsp_valid), 0);
    end
    $display("txn abort fetch req=1 by reset");
    txn("rd6_after_rst", 0, 2'd0, 4'h6, 4'h0, 4'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case the directed sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
